// File: rtl/debug_bus_arbiter_if.sv
// Debug probe bus bundle: two requester ports plus the shared address/data probe.
// The arbiter takes the slave modport; consumers and the debug mux drive the master side.
interface debug_bus_arbiter_if #(
  parameter int AW = 7,
  parameter int DW = 40
);
  logic          req0;
  logic [AW-1:0] addr0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;
  logic          req1;
  logic [AW-1:0] addr1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  modport slave (
    input  req0, addr0, req1, addr1, dbg_data,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, dbg_addr
  );

  modport master (
    output req0, addr0, req1, addr1, dbg_data,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, dbg_addr
  );
endinterface

// File: rtl/debug_bus_arbiter.sv
// Two-port arbiter for the CPU debug probe bus with port-1 anti-starvation and tagged returns.
// Define DBG_ARB_PERF_EN to add saturating handshake / force-grant counters.
module debug_bus_arbiter #(
  parameter int AW         = 7,
  parameter int DW         = 40,
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                rst,
  debug_bus_arbiter_if.slave  bus
`ifdef DBG_ARB_PERF_EN
  ,
  output logic [15:0]         perf_gnt0,
  output logic [15:0]         perf_gnt1,
  output logic [15:0]         perf_force
`endif
);

  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_FORCE1 = 1'b1;
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [0:0]    state_q, state_d;
  logic [7:0]    starve_cnt_q, starve_cnt_d;
  logic [AW-1:0] dbg_addr_q, dbg_addr_d;
  logic [LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic [LAT-1:0] port_pipe_q, port_pipe_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          gnt0, gnt1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (state_q == ST_NORMAL) begin
        gnt0 = bus.req0;
        gnt1 = bus.req1 & ~bus.req0;
      end else begin
        gnt1 = bus.req1;
        gnt0 = bus.req0 & ~bus.req1;
      end
    end

    starve_cnt_d = starve_cnt_q;
    if (!bus.req1 || gnt1)
      starve_cnt_d = 8'd0;
    else if (starve_cnt_q != STARVE_LIM)
      starve_cnt_d = starve_cnt_q + 8'd1;

    // Switch on the edge the count reaches the limit so port 0 gets exactly STARVE_MAX grants.
    state_d = state_q;
    if (state_q == ST_NORMAL) begin
      if (starve_cnt_d == STARVE_LIM) state_d = ST_FORCE1;
    end else if (gnt1 || !bus.req1) begin
      state_d = ST_NORMAL;
    end

    dbg_addr_d = dbg_addr_q;
    if (gnt0)      dbg_addr_d = bus.addr0;
    else if (gnt1) dbg_addr_d = bus.addr1;

    vld_pipe_d     = '0;
    port_pipe_d    = '0;
    vld_pipe_d[0]  = gnt0 | gnt1;
    port_pipe_d[0] = gnt1;
    for (int k = 1; k < LAT; k++) begin
      vld_pipe_d[k]  = vld_pipe_q[k-1];
      port_pipe_d[k] = port_pipe_q[k-1];
    end

    // The tag leaving the last stage marks the cycle dbg_data belongs to its owner.
    rvalid0_d = vld_pipe_q[LAT-1] & ~port_pipe_q[LAT-1];
    rvalid1_d = vld_pipe_q[LAT-1] &  port_pipe_q[LAT-1];
    rdata0_d  = rvalid0_d ? bus.dbg_data : rdata0_q;
    rdata1_d  = rvalid1_d ? bus.dbg_data : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_NORMAL;
      starve_cnt_q <= '0;
      dbg_addr_q   <= '0;
      vld_pipe_q   <= '0;
      port_pipe_q  <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      dbg_addr_q   <= dbg_addr_d;
      vld_pipe_q   <= vld_pipe_d;
      port_pipe_q  <= port_pipe_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.dbg_addr = dbg_addr_q;
  assign bus.rvalid0  = rvalid0_q;
  assign bus.rvalid1  = rvalid1_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;

`ifdef DBG_ARB_PERF_EN
  logic [15:0] perf_gnt0_q, perf_gnt0_d;
  logic [15:0] perf_gnt1_q, perf_gnt1_d;
  logic [15:0] perf_force_q, perf_force_d;

  always_comb begin
    perf_gnt0_d  = perf_gnt0_q;
    perf_gnt1_d  = perf_gnt1_q;
    perf_force_d = perf_force_q;
    if (gnt0 && perf_gnt0_q != 16'hFFFF) perf_gnt0_d = perf_gnt0_q + 16'd1;
    if (gnt1 && perf_gnt1_q != 16'hFFFF) perf_gnt1_d = perf_gnt1_q + 16'd1;
    if (state_q == ST_NORMAL && state_d == ST_FORCE1 && perf_force_q != 16'hFFFF)
      perf_force_d = perf_force_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_gnt0_q  <= '0;
      perf_gnt1_q  <= '0;
      perf_force_q <= '0;
    end else begin
      perf_gnt0_q  <= perf_gnt0_d;
      perf_gnt1_q  <= perf_gnt1_d;
      perf_force_q <= perf_force_d;
    end
  end

  assign perf_gnt0  = perf_gnt0_q;
  assign perf_gnt1  = perf_gnt1_q;
  assign perf_force = perf_force_q;
`endif

endmodule

// File: tb/tb_debug_bus_arbiter.sv
// Directed bench for debug_bus_arbiter: a LAT=1 and a LAT=3 instance, expected returns
// queued at grant time and popped when rvalid appears.
module tb_debug_bus_arbiter;
  localparam int AW = 7;
  localparam int DW = 40;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  debug_bus_arbiter_if #(.AW(AW), .DW(DW)) if1 ();
  debug_bus_arbiter_if #(.AW(AW), .DW(DW)) if3 ();

`ifdef DBG_ARB_PERF_EN
  logic [15:0] pg0_1, pg1_1, pf_1, pg0_3, pg1_3, pf_3;
`endif

  debug_bus_arbiter #(.AW(AW), .DW(DW), .LAT(1), .STARVE_MAX(8)) u_l1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
`ifdef DBG_ARB_PERF_EN
    , .perf_gnt0(pg0_1), .perf_gnt1(pg1_1), .perf_force(pf_1)
`endif
  );

  debug_bus_arbiter #(.AW(AW), .DW(DW), .LAT(3), .STARVE_MAX(8)) u_l3 (
    .clk(clk), .rst(rst), .bus(if3.slave)
`ifdef DBG_ARB_PERF_EN
    , .perf_gnt0(pg0_3), .perf_gnt1(pg1_3), .perf_force(pf_3)
`endif
  );

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return 40'(a) * 40'h1_0000_0001;
  endfunction

  // Debug mux model: combinational for LAT=1; for LAT=3 the mux is a 2-stage pipe so the
  // data seen at the capture edge belongs to the address granted LAT edges earlier.
  logic [AW-1:0] a3_d1, a3_d2;
  always @(posedge clk) begin
    a3_d1 <= if3.dbg_addr;
    a3_d2 <= a3_d1;
  end
  assign if1.dbg_data = rom(if1.dbg_addr);
  assign if3.dbg_data = rom(a3_d2);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q1.size() != 0 || q3.size() != 0); i++) tick();
    chk("drain", 64'(q1.size() + q3.size()), 64'd0);
  endtask

  exp_t e1, e3;
  always @(negedge clk) begin
    chk("gnt_excl1", 64'(if1.gnt0 & if1.gnt1), 64'd0);
    chk("gnt_excl3", 64'(if3.gnt0 & if3.gnt1), 64'd0);
    if (if1.rvalid0 | if1.rvalid1) begin
      chk("rv_excl1", 64'(if1.rvalid0 & if1.rvalid1), 64'd0);
      chk("rv_expected1", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chk("rv_port1", 64'(if1.rvalid1), 64'(e1.port));
        chk("rdata1", 64'(e1.port ? if1.rdata1 : if1.rdata0), 64'(e1.data));
      end
    end
    if (if3.rvalid0 | if3.rvalid1) begin
      chk("rv_excl3", 64'(if3.rvalid0 & if3.rvalid1), 64'd0);
      chk("rv_expected3", 64'(q3.size() != 0), 64'd1);
      if (q3.size() != 0) begin
        e3 = q3.pop_front();
        chk("rv_port3", 64'(if3.rvalid1), 64'(e3.port));
        chk("rdata3", 64'(e3.port ? if3.rdata1 : if3.rdata0), 64'(e3.data));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_g1;
`ifdef DBG_ARB_PERF_EN
    logic [15:0] pf0;
`endif
    rst = 1'b1;
    if1.req0 = 0; if1.addr0 = '0; if1.req1 = 0; if1.addr1 = '0;
    if3.req0 = 0; if3.addr0 = '0; if3.req1 = 0; if3.addr1 = '0;
    tick();
    if1.req0 = 1'b1;
    #1 chk("gnt0_in_rst", 64'(if1.gnt0), 64'd0);
    if1.req0 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_dbg_addr", 64'(if1.dbg_addr), 64'd0);
    chk("rst_rvalid0", 64'(if1.rvalid0), 64'd0);
    chk("rst_rdata0", 64'(if1.rdata0), 64'd0);
    chk("rst_rdata1_l3", 64'(if3.rdata1), 64'd0);

    // LAT=1 single port-0 read
    if1.req0 = 1'b1; if1.addr0 = 7'h05;
    #1 chk("t1_gnt0", 64'(if1.gnt0), 64'd1);
    chk("t1_gnt1", 64'(if1.gnt1), 64'd0);
    q1.push_back('{1'b0, rom(7'h05)});
    tick();
    if1.req0 = 1'b0;
    chk("t1_dbg_addr", 64'(if1.dbg_addr), 64'd5);
    chk("t1_rvalid_early", 64'(if1.rvalid0), 64'd0);
    tick();
    chk("t1_rvalid0", 64'(if1.rvalid0), 64'd1);
    chk("t1_rdata0", 64'(if1.rdata0), 64'h5_0000_0005);
    drain();

    // Both ports held: 8 port-0 grants then one forced port-1 grant, repeating
`ifdef DBG_ARB_PERF_EN
    pf0 = pf_1;
`endif
    if1.req0 = 1'b1; if1.addr0 = 7'h11;
    if1.req1 = 1'b1; if1.addr1 = 7'h22;
    for (int i = 0; i < 18; i++) begin
      exp_g1 = (i % 9) == 8;
      #1 chk("t2_gnt1", 64'(if1.gnt1), 64'(exp_g1));
      chk("t2_gnt0", 64'(if1.gnt0), 64'(!exp_g1));
      q1.push_back(exp_g1 ? '{1'b1, rom(7'h22)} : '{1'b0, rom(7'h11)});
      tick();
    end
    if1.req0 = 1'b0; if1.req1 = 1'b0;
    drain();
`ifdef DBG_ARB_PERF_EN
    chk("t2_perf_force", 64'(pf_1), 64'(pf0 + 16'd2));
`endif

    // Port 1 alone: granted every cycle, never starving
    if1.req1 = 1'b1; if1.addr1 = 7'h33;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t5_gnt1", 64'(if1.gnt1), 64'd1);
      chk("t5_gnt0", 64'(if1.gnt0), 64'd0);
      q1.push_back('{1'b1, rom(7'h33)});
      tick();
    end
    chk("t5_starve_cnt", 64'(u_l1.starve_cnt_q), 64'd0);
    chk("t5_state", 64'(u_l1.state_q), 64'd0);
    if1.req1 = 1'b0;
    #1 chk("t5_drop_gnt1", 64'(if1.gnt1), 64'd0);
    drain();

    // LAT=3 back-to-back alternating grants
    tick();
    if3.req0 = 1'b1; if3.addr0 = 7'h01;
    #1 chk("t3_gnt0_a", 64'(if3.gnt0), 64'd1);
    q3.push_back('{1'b0, rom(7'h01)});
    tick();
    if3.req0 = 1'b0; if3.req1 = 1'b1; if3.addr1 = 7'h02;
    #1 chk("t3_gnt1", 64'(if3.gnt1), 64'd1);
    q3.push_back('{1'b1, rom(7'h02)});
    tick();
    if3.req1 = 1'b0; if3.req0 = 1'b1; if3.addr0 = 7'h03;
    #1 chk("t3_gnt0_b", 64'(if3.gnt0), 64'd1);
    q3.push_back('{1'b0, rom(7'h03)});
    tick();
    if3.req0 = 1'b0;
    chk("t3_rv_early", 64'(if3.rvalid0 | if3.rvalid1), 64'd0);
    tick();
    chk("t3_rv0_first", 64'(if3.rvalid0), 64'd1);
    tick();
    chk("t3_rv1_second", 64'(if3.rvalid1), 64'd1);
    tick();
    chk("t3_rv0_third", 64'(if3.rvalid0), 64'd1);
    drain();

    // LAT=3 reset mid-flight discards the tag
    tick();
    if3.req1 = 1'b1; if3.addr1 = 7'h09;
    #1 chk("t4_gnt1", 64'(if3.gnt1), 64'd1);
    tick();
    if3.req1 = 1'b0;
    chk("t4_dbg_addr_pre", 64'(if3.dbg_addr), 64'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("t4_dbg_addr", 64'(if3.dbg_addr), 64'd0);
    chk("t4_rdata1", 64'(if3.rdata1), 64'd0);
    chk("t4_rdata0", 64'(if3.rdata0), 64'd0);

`ifdef DBG_ARB_PERF_EN
    if1.req0 = 1'b1; if1.addr0 = 7'h01;
    for (int i = 0; i < 70000; i++) begin
      q1.push_back('{1'b0, rom(7'h01)});
      tick();
    end
    if1.req0 = 1'b0;
    drain();
    chk("perf_gnt0_sat", 64'(pg0_1), 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
